// File: rtl/greensc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | greensc_ctrl_if : pixel stream in, keyer configuration out           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface greensc_ctrl_if;
    logic [12:0] row;
    logic [12:0] col;
    logic        pix_valid;
    logic [8:0]  hue_in;
    logic        en_sw;
    logic        cal_req;
    logic        gsc_en;
    logic [8:0]  key_lo;
    logic [8:0]  key_hi;
    logic [8:0]  bg_offset;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_err;

    modport slave (
        input  row, col, pix_valid, hue_in, en_sw, cal_req,
        output gsc_en, key_lo, key_hi, bg_offset, cal_busy, cal_done, cal_err
    );

    modport master (
        output row, col, pix_valid, hue_in, en_sw, cal_req,
        input  gsc_en, key_lo, key_hi, bg_offset, cal_busy, cal_done, cal_err
    );
endinterface
`default_nettype wire

// File: rtl/greensc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | greensc_ctrl : frame-aligned keyer enable, scroll and hue calibration |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module greensc_ctrl #(
    parameter int CENTER_ROW  = 240,
    parameter int CENTER_COL  = 320,
    parameter int CAL_FRAMES  = 4,
    parameter int MARGIN      = 30,
    parameter int DEF_LO      = 90,
    parameter int DEF_HI      = 150,
    parameter int SCROLL_STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    greensc_ctrl_if.slave gsc_io
);
    localparam int         LOG2_N = $clog2(CAL_FRAMES);
    localparam int         ACC_W  = 9 + LOG2_N;
    localparam logic [4:0] C_NSAMP_MAX = 5'(CAL_FRAMES);
    localparam logic [5:0] C_WDOG_MAX  = 6'(2 * CAL_FRAMES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_SAMPLE  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_APPLY   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             en_meta_q, en_s_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       nsamp_q, nsamp_d;
    logic [5:0]       wdog_q, wdog_d;
    logic [8:0]       new_lo_q, new_lo_d, new_hi_q, new_hi_d;
    logic             gsc_en_q, gsc_en_d;
    logic [8:0]       key_lo_q, key_lo_d, key_hi_q, key_hi_d;
    logic [8:0]       bg_q, bg_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             w_fs, w_cs, w_samp_done, w_wdog_trip;
    logic [8:0]       w_hue_clip, w_avg;
    logic [9:0]       w_bg_sum;
    logic [10:0]      w_avg_ext, w_avg_hi;

    assign w_fs = gsc_io.pix_valid && (gsc_io.row == 13'd0) && (gsc_io.col == 13'd0);
    assign w_cs = gsc_io.pix_valid && (gsc_io.row == 13'(CENTER_ROW))
                                   && (gsc_io.col == 13'(CENTER_COL));

    assign w_hue_clip = (gsc_io.hue_in > 9'd359) ? 9'd359 : gsc_io.hue_in;
    assign w_avg      = 9'(acc_q >> LOG2_N);
    assign w_avg_ext  = {2'b00, w_avg};
    assign w_avg_hi   = w_avg_ext + 11'(MARGIN);
    assign w_bg_sum   = {1'b0, bg_q} + 10'(SCROLL_STEP);

    // A completing sample takes priority over a watchdog expiry in the same cycle.
    assign w_samp_done = (state_q == S_SAMPLE) && w_cs && ((nsamp_q + 5'd1) == C_NSAMP_MAX);
    assign w_wdog_trip = (state_q == S_SAMPLE) && w_fs && !w_samp_done
                         && ((wdog_q + 6'd1) == C_WDOG_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (gsc_io.cal_req) state_d = S_ARM;
            S_ARM:     if (w_fs) state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (w_samp_done)      state_d = S_COMPUTE;
                else if (w_wdog_trip) state_d = S_IDLE;
            end
            S_COMPUTE: state_d = S_APPLY;
            S_APPLY:   if (w_fs) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        nsamp_d  = nsamp_q;
        wdog_d   = wdog_q;
        new_lo_d = new_lo_q;
        new_hi_d = new_hi_q;
        gsc_en_d = gsc_en_q;
        key_lo_d = key_lo_q;
        key_hi_d = key_hi_q;
        bg_d     = bg_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Enable and scroll only move on frame boundaries so the keyer never sees a mid-frame change.
        if (w_fs) begin
            gsc_en_d = en_s_q && (state_q == S_IDLE);
            if (gsc_en_q) begin
                bg_d = (w_bg_sum >= 10'd360) ? 9'(w_bg_sum - 10'd360) : w_bg_sum[8:0];
            end
        end

        case (state_q)
            S_ARM: begin
                if (w_fs) begin
                    acc_d   = '0;
                    nsamp_d = '0;
                    wdog_d  = '0;
                end
            end
            S_SAMPLE: begin
                if (w_cs) begin
                    acc_d   = acc_q + ACC_W'(w_hue_clip);
                    nsamp_d = nsamp_q + 5'd1;
                end
                if (w_fs) wdog_d = wdog_q + 6'd1;
                err_d = w_wdog_trip;
            end
            S_COMPUTE: begin
                new_lo_d = (w_avg_ext < 11'(MARGIN)) ? 9'd0 : 9'(w_avg_ext - 11'(MARGIN));
                new_hi_d = (w_avg_hi > 11'd359) ? 9'd359 : w_avg_hi[8:0];
            end
            S_APPLY: begin
                if (w_fs) begin
                    key_lo_d = new_lo_q;
                    key_hi_d = new_hi_q;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_meta_q <= 1'b0;
            en_s_q    <= 1'b0;
            acc_q     <= '0;
            nsamp_q   <= '0;
            wdog_q    <= '0;
            new_lo_q  <= 9'(DEF_LO);
            new_hi_q  <= 9'(DEF_HI);
            gsc_en_q  <= 1'b0;
            key_lo_q  <= 9'(DEF_LO);
            key_hi_q  <= 9'(DEF_HI);
            bg_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_meta_q <= gsc_io.en_sw;
            en_s_q    <= en_meta_q;
            acc_q     <= acc_d;
            nsamp_q   <= nsamp_d;
            wdog_q    <= wdog_d;
            new_lo_q  <= new_lo_d;
            new_hi_q  <= new_hi_d;
            gsc_en_q  <= gsc_en_d;
            key_lo_q  <= key_lo_d;
            key_hi_q  <= key_hi_d;
            bg_q      <= bg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign gsc_io.gsc_en    = gsc_en_q;
    assign gsc_io.key_lo    = key_lo_q;
    assign gsc_io.key_hi    = key_hi_q;
    assign gsc_io.bg_offset = bg_q;
    assign gsc_io.cal_busy  = busy_q;
    assign gsc_io.cal_done  = done_q;
    assign gsc_io.cal_err   = err_q;
endmodule
`default_nettype wire
